// File: rtl/meter_controller.sv
// Parking-meter style countdown controller: add/load requests, a 1 s countdown,
// and a display enable that blinks according to how much time is left.
module meter_controller #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MAX_TIME = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        u,
  input  logic        l,
  input  logic        r,
  input  logic        d,
  input  logic        sw0,
  input  logic        sw1,
  output logic [15:0] time_left,
  output logic [1:0]  state,
  output logic        disp_on,
  output logic        accept
);
  localparam int unsigned HALF = TICK_DIV / 2;
  localparam int          DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [1:0]  ST_EMPTY = 2'b00;
  localparam logic [1:0]  ST_LOW   = 2'b01;
  localparam logic [1:0]  ST_OK    = 2'b10;
  localparam logic [16:0] MAX17    = 17'(MAX_TIME);
  localparam logic [15:0] MAX16    = 16'(MAX_TIME);

  logic [DW-1:0] div_cnt;
  logic          sec_ph;
  logic          sw0_q, sw1_q;

  logic          half_tick, sec_tick;
  logic          sw0_rise, sw1_rise, load, add;
  logic [16:0]   inc, sum;
  logic [15:0]   sat, load_val, t_next;
  logic [1:0]    st_next;
  logic          disp_next, tick_h, tick_s;

  assign half_tick = (div_cnt == DW'(HALF - 1));
  assign sec_tick  = half_tick & sec_ph;
  assign sw0_rise  = sw0 & ~sw0_q;
  assign sw1_rise  = sw1 & ~sw1_q;
  assign load      = sw0_rise | sw1_rise;
  assign add       = u | l | r | d;
  // A load restarts the divider, so its tick (if any) is discarded everywhere.
  assign tick_h    = half_tick & ~load;
  assign tick_s    = sec_tick & ~load;

  always_comb begin
    inc = 17'd0;
    if (u)      inc = 17'd10;
    else if (l) inc = 17'd180;
    else if (r) inc = 17'd200;
    else if (d) inc = 17'd550;
    load_val = sw0_rise ? 16'd10 : 16'd205;
    sum      = {1'b0, time_left} + inc;
    sat      = (sum > MAX17) ? MAX16 : sum[15:0];
  end

  always_comb begin
    t_next = time_left;
    if (load)
      t_next = load_val;
    else if (add)
      t_next = sec_tick ? (sat - 16'd1) : sat;
    else if (sec_tick && (time_left != 16'd0))
      t_next = time_left - 16'd1;
  end

  always_comb begin
    if (t_next == 16'd0)        st_next = ST_EMPTY;
    else if (t_next < 16'd180)  st_next = ST_LOW;
    else                        st_next = ST_OK;
  end

  // Entering a new state always relights the digits, overriding any toggle.
  always_comb begin
    disp_next = disp_on;
    if (st_next != state)
      disp_next = 1'b1;
    else begin
      case (st_next)
        ST_OK:   disp_next = 1'b1;
        ST_LOW:  disp_next = disp_on ^ tick_s;
        default: disp_next = disp_on ^ tick_h;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      sec_ph    <= 1'b0;
      sw0_q     <= sw0;
      sw1_q     <= sw1;
      time_left <= 16'd0;
      state     <= ST_EMPTY;
      disp_on   <= 1'b1;
      accept    <= 1'b0;
    end else begin
      sw0_q     <= sw0;
      sw1_q     <= sw1;
      time_left <= t_next;
      state     <= st_next;
      disp_on   <= disp_next;
      accept    <= load | add;
      if (load) begin
        div_cnt <= '0;
        sec_ph  <= 1'b0;
      end else if (half_tick) begin
        div_cnt <= '0;
        sec_ph  <= ~sec_ph;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_meter_controller.sv
// Self-checking bench for meter_controller with TICK_DIV = 10 (1 s = 10 clk).
module tb_meter_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        u = 0, l = 0, r = 0, d = 0, sw0 = 0, sw1 = 0;
  logic [15:0] time_left;
  logic [1:0]  state;
  logic        disp_on, accept;

  meter_controller #(.TICK_DIV(10), .MAX_TIME(9999)) dut (
    .clk(clk), .rst(rst), .u(u), .l(l), .r(r), .d(d), .sw0(sw0), .sw1(sw1),
    .time_left(time_left), .state(state), .disp_on(disp_on), .accept(accept)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] U    = 6'b100000;
  localparam logic [5:0] L    = 6'b010000;
  localparam logic [5:0] R    = 6'b001000;
  localparam logic [5:0] D    = 6'b000100;
  localparam logic [5:0] SW0  = 6'b000010;
  localparam logic [5:0] SW1  = 6'b000001;
  localparam logic [1:0] EMPTY = 2'd0, LOW = 2'd1, OK = 2'd2;

  typedef struct {
    logic [5:0]  in;
    logic [15:0] t;
    logic [1:0]  st;
    logic        acc;
    logic        dsp;
  } vec_t;

  vec_t  exp_q[$];
  vec_t  tbl[12];
  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  task automatic cmp(input string fld, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %0d want %0d", tag, fld, got, want);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    cmp("time_left", 32'(time_left), 32'(e.t));
    cmp("state",     32'(state),     32'(e.st));
    cmp("accept",    32'(accept),    32'(e.acc));
    cmp("disp_on",   32'(disp_on),   32'(e.dsp));
  endtask

  task automatic apply(input vec_t v);
    {u, l, r, d, sw0, sw1} = v.in;
    exp_q.push_back(v);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic step(input logic [5:0] in, input int t, input logic [1:0] st,
                      input logic acc, input logic dsp);
    vec_t v;
    v.in = in; v.t = 16'(t); v.st = st; v.acc = acc; v.dsp = dsp;
    apply(v);
  endtask

  task automatic idle(input int n, input logic [5:0] in);
    {u, l, r, d, sw0, sw1} = in;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {u, l, r, d, sw0, sw1} = NONE;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp("rst_time", 32'(time_left), 32'd0);
    cmp("rst_state", 32'(state), 32'(EMPTY));
    cmp("rst_accept", 32'(accept), 32'd0);
    cmp("rst_disp", 32'(disp_on), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Priority / add table, starting right after reset (no tick before edge 10).
    tbl[0]  = '{U | L | D,     10,   LOW, 1'b1, 1'b1};
    tbl[1]  = '{L,             190,  OK,  1'b1, 1'b1};
    tbl[2]  = '{R,             390,  OK,  1'b1, 1'b1};
    tbl[3]  = '{NONE,          390,  OK,  1'b0, 1'b1};
    tbl[4]  = '{L | R | D,     570,  OK,  1'b1, 1'b1};
    tbl[5]  = '{R | D,         770,  OK,  1'b1, 1'b1};
    tbl[6]  = '{D,             1320, OK,  1'b1, 1'b1};
    tbl[7]  = '{SW1 | U,       205,  OK,  1'b1, 1'b1};
    tbl[8]  = '{SW1 | U,       215,  OK,  1'b1, 1'b1};
    tbl[9]  = '{SW1 | SW0 | L, 10,   LOW, 1'b1, 1'b1};
    tbl[10] = '{SW1 | SW0,     10,   LOW, 1'b0, 1'b1};
    tbl[11] = '{R,             210,  OK,  1'b1, 1'b1};

    tag = "reset";
    do_reset();

    tag = "countdown";
    step(U, 10, LOW, 1, 1);          // e1
    step(NONE, 10, LOW, 0, 1);       // e2
    idle(7, NONE);
    step(NONE, 9, LOW, 0, 0);        // e10 first second
    idle(9, NONE);
    step(NONE, 8, LOW, 0, 1);        // e20
    idle(79, NONE);
    step(NONE, 0, EMPTY, 0, 1);      // e100 enter EMPTY
    idle(4, NONE);
    step(NONE, 0, EMPTY, 0, 0);      // e105 half-second blink
    idle(4, NONE);
    step(NONE, 0, EMPTY, 0, 1);      // e110 no underflow

    tag = "table";
    do_reset();
    for (int i = 0; i < 12; i++) apply(tbl[i]);

    tag = "saturate";
    do_reset();
    idle(9, D);                      // e1..e9 -> 4950
    step(NONE, 4949, OK, 0, 1);      // e10
    idle(9, D);                      // -> 9899
    step(NONE, 9898, OK, 0, 1);      // e20
    step(D, 9999, OK, 1, 1);         // e21 clamps
    idle(88, NONE);
    step(NONE, 9990, OK, 0, 1);      // e110
    step(D, 9999, OK, 1, 1);         // e111
    step(D, 9999, OK, 1, 1);         // e112 add at ceiling still accepted
    idle(7, NONE);
    step(D, 9998, OK, 1, 1);         // e120 add with tick
    step(NONE, 9998, OK, 0, 1);

    tag = "switch";
    do_reset();
    step(SW1 | D, 205, OK, 1, 1);    // e1 load wins
    idle(29, SW1);
    step(SW1, 202, OK, 0, 1);        // e31 held level, ticks only
    step(SW0, 10, LOW, 1, 1);        // e32 sw0 load
    idle(8, SW0);
    step(SW0, 10, LOW, 0, 1);        // 9 clk after load, no tick yet
    step(SW0, 9, LOW, 0, 0);         // 10 clk after load

    tag = "low_boundary";
    do_reset();
    step(U, 10, LOW, 1, 1);
    step(L, 190, OK, 1, 1);
    idle(97, NONE);
    step(NONE, 180, OK, 0, 1);       // e100
    idle(9, NONE);
    step(NONE, 179, LOW, 0, 1);      // e110 enter LOW lit
    idle(9, NONE);
    step(NONE, 178, LOW, 0, 0);      // e120
    idle(9, NONE);
    step(NONE, 177, LOW, 0, 1);      // e130

    tag = "mid_reset";
    do_reset();
    step(R, 200, OK, 1, 1);
    step(R, 400, OK, 1, 1);
    {u, l, r, d, sw0, sw1} = U | SW0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    u = 1'b0;
    cmp("rst_override_time", 32'(time_left), 32'd0);
    cmp("rst_override_state", 32'(state), 32'(EMPTY));
    cmp("rst_override_accept", 32'(accept), 32'd0);
    step(SW0, 0, EMPTY, 0, 1);       // e1 held switch does not load
    step(SW0 | U, 10, LOW, 1, 1);    // e2
    idle(6, SW0);
    step(SW0, 10, LOW, 0, 1);        // e9 no residual phase
    step(SW0, 9, LOW, 0, 0);         // e10

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
